// File: rtl/musb_port_arbiter.sv
// Two-port (instruction/data) arbiter onto one shared single-port memory bus.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise dport has fixed priority.
module musb_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iport_address,
    input  logic [3:0]  iport_wr,
    input  logic        iport_enable,
    output logic [31:0] iport_data_i,
    output logic        iport_ready,
    output logic        iport_error,
    input  logic [31:0] dport_address,
    input  logic [31:0] dport_data_o,
    input  logic [3:0]  dport_wr,
    input  logic        dport_enable,
    output logic [31:0] dport_data_i,
    output logic        dport_ready,
    output logic        dport_error,
    output logic [31:0] bus_address,
    output logic [31:0] bus_data_o,
    output logic [3:0]  bus_wr,
    output logic        bus_enable,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ready,
    input  logic        bus_error
);

    // state   | meaning
    // IDLE    | no grant; arbitrate pending requests
    // GRANT_I | iport owns the bus
    // GRANT_D | dport owns the bus
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    state_t      state;
    logic        last_grant;   // 0 = iport, 1 = dport
    logic [7:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  wr_q;

    logic granted;
    logic owner_en;
    logic to_armed;
    logic timeout_hit;
    logic resp_rdy;
    logic resp_err;
    logic pick_d;
    logic pick_i;

    assign granted  = (state == GRANT_I) || (state == GRANT_D);
    assign owner_en = (state == GRANT_I) ? iport_enable : dport_enable;
    assign to_armed = (TIMEOUT != 0) && (({24'd0, wait_cnt} + 32'd1) == TIMEOUT);

    // Timeout only fires if the bus has not answered; a dropped enable aborts silently.
    assign timeout_hit = granted && owner_en && to_armed && !bus_ready && !bus_error;
    assign resp_err    = granted && owner_en && (bus_error || timeout_hit);
    assign resp_rdy    = granted && owner_en && bus_ready && !bus_error;

    assign pick_d = dport_enable && (!iport_enable || !RR_EN || !last_grant);
    assign pick_i = iport_enable && !pick_d;

    assign bus_enable  = granted && !timeout_hit;
    assign bus_address = granted ? addr_q : 32'd0;
    assign bus_data_o  = granted ? data_q : 32'd0;
    assign bus_wr      = granted ? wr_q : 4'd0;

    assign iport_ready = (state == GRANT_I) && resp_rdy;
    assign iport_error = (state == GRANT_I) && resp_err;
    assign dport_ready = (state == GRANT_D) && resp_rdy;
    assign dport_error = (state == GRANT_D) && resp_err;

    assign iport_data_i = rst ? bus_data_i : 32'd0;
    assign dport_data_i = rst ? bus_data_i : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            wait_cnt   <= 8'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            wr_q       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    if (pick_d) begin
                        state      <= GRANT_D;
                        last_grant <= 1'b1;
                        addr_q     <= dport_address;
                        data_q     <= dport_data_o;
                        wr_q       <= dport_wr;
                    end else if (pick_i) begin
                        state      <= GRANT_I;
                        last_grant <= 1'b0;
                        addr_q     <= iport_address;
                        data_q     <= 32'd0;
                        wr_q       <= iport_wr;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (!owner_en || bus_ready || bus_error || timeout_hit) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
